// File: rtl/capture_pkg.sv
// Shared state encoding for the pre-trigger capture block.
package capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FILL      = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_READ      = 3'd4
    } cap_state_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port sample store: one write port, one registered read port (1-cycle latency).
module sdp_ram #(
    parameter int DW    = 8,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/pretrig_capture.sv
// Ring-buffer capture with PRE samples of history before a trigger, then a
// stall-safe streaming read-out of the DEPTH-sample window.
//
// state        | meaning
// ST_IDLE      | waiting for arm
// ST_FILL      | storing the first PRE samples, trig ignored
// ST_WAIT_TRIG | ring keeps running, waiting for en && trig
// ST_POST      | storing the remaining post-trigger samples
// ST_READ      | streaming the window out through the skid buffer
module pretrig_capture
    import capture_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 64,
    parameter int PRE   = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] din,
    input  logic          arm,
    input  logic          trig,
    output logic          busy,
    output logic          triggered,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          dout_last,
    output logic          done
);

    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0) || (PRE < 0) || (PRE >= DEPTH)) begin : g_param_check
        $fatal(1, "pretrig_capture: DEPTH must be a power of two >= 4 and 0 <= PRE < DEPTH");
    end

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PRE_A     = AW'(PRE);
    localparam logic [AW-1:0] FILL_LOAD = AW'((PRE > 0) ? PRE - 1 : 0);
    localparam logic [AW-1:0] POST_LOAD = AW'((DEPTH - PRE >= 2) ? DEPTH - PRE - 2 : 0);
    localparam logic [AW:0]   RD_TOTAL  = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   RD_LAST   = (AW + 1)'(DEPTH - 1);
    localparam cap_state_t    ARM_STATE  = (PRE == 0) ? ST_WAIT_TRIG : ST_FILL;
    localparam cap_state_t    TRIG_STATE = (PRE == DEPTH - 1) ? ST_READ : ST_POST;

    cap_state_t    state, state_nxt;
    logic          we;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] cnt;
    logic [AW-1:0] trig_addr;

    logic [AW:0]   rd_cnt;
    logic [AW-1:0] rd_addr;
    logic          issue;
    logic          inflight;
    logic          inflight_last;
    logic [DW-1:0] ram_q;

    logic [1:0]    buf_cnt;
    logic [1:0]    occ;
    logic [DW-1:0] buf0, buf1;
    logic          buf0_last, buf1_last;
    logic          xfer;

    assign busy       = (state != ST_IDLE);
    assign triggered  = (state == ST_POST) || (state == ST_READ);
    assign dout_valid = (buf_cnt != 2'd0);
    assign dout_last  = dout_valid && buf0_last;
    assign dout       = buf0;
    assign xfer       = dout_valid && dout_ready;

    always_comb begin
        state_nxt = state;
        we        = 1'b0;
        case (state)
            ST_IDLE:      if (arm && !done) state_nxt = ARM_STATE;
            ST_FILL: begin
                we = en;
                if (en && cnt == '0) state_nxt = ST_WAIT_TRIG;
            end
            ST_WAIT_TRIG: begin
                we = en;
                if (en && trig) state_nxt = TRIG_STATE;
            end
            ST_POST: begin
                we = en;
                if (en && cnt == '0) state_nxt = ST_READ;
            end
            ST_READ:      if (xfer && buf0_last) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // cnt is a down-counter of samples still to write before the next phase change
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            cnt       <= '0;
            trig_addr <= '0;
            done      <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == ST_READ) && xfer && buf0_last;
            if (state == ST_IDLE) begin
                if (arm && !done) begin
                    wr_ptr <= '0;
                    cnt    <= FILL_LOAD;
                end
            end else if (we) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (state == ST_WAIT_TRIG) begin
                    if (trig) begin
                        trig_addr <= wr_ptr;
                        cnt       <= POST_LOAD;
                    end
                end else if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    // Reads are only issued when the skid buffer is guaranteed room for the returning word
    assign occ     = buf_cnt + {1'b0, inflight};
    assign issue   = (state == ST_READ) && (rd_cnt != RD_TOTAL) && ((occ < 2'd2) || xfer);
    assign rd_addr = (trig_addr - PRE_A) + rd_cnt[AW-1:0];

    always_ff @(posedge clk) begin
        if (rst || state != ST_READ) begin
            rd_cnt        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue && (rd_cnt == RD_LAST);
            if (issue) rd_cnt <= rd_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_cnt   <= 2'd0;
            buf0      <= '0;
            buf1      <= '0;
            buf0_last <= 1'b0;
            buf1_last <= 1'b0;
        end else begin
            case ({inflight, xfer})
                2'b11: begin
                    if (buf_cnt == 2'd2) begin
                        buf0      <= buf1;
                        buf0_last <= buf1_last;
                        buf1      <= ram_q;
                        buf1_last <= inflight_last;
                    end else begin
                        buf0      <= ram_q;
                        buf0_last <= inflight_last;
                    end
                end
                2'b10: begin
                    if (buf_cnt == 2'd0) begin
                        buf0      <= ram_q;
                        buf0_last <= inflight_last;
                    end else begin
                        buf1      <= ram_q;
                        buf1_last <= inflight_last;
                    end
                    buf_cnt <= buf_cnt + 2'd1;
                end
                2'b01: begin
                    buf0      <= buf1;
                    buf0_last <= buf1_last;
                    buf1_last <= 1'b0;
                    buf_cnt   <= buf_cnt - 2'd1;
                end
                default: ;
            endcase
        end
    end

    sdp_ram #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (din),
        .re    (issue),
        .raddr (rd_addr),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_pretrig_capture.sv
// Bench for pretrig_capture: two instances (PRE=4 and PRE=0) share stimulus and are
// checked against a window model built from the list of enabled samples.
module tb_pretrig_capture;

    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, en, arm, trig, dout_ready;
    logic [DW-1:0] din;
    logic          busy[2], triggered[2], dout_valid[2], dout_last[2], done[2];
    logic [DW-1:0] dout[2];

    pretrig_capture #(.DW(DW), .DEPTH(DEPTH), .PRE(4)) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .din(din), .arm(arm), .trig(trig),
        .busy(busy[0]), .triggered(triggered[0]), .dout(dout[0]),
        .dout_valid(dout_valid[0]), .dout_ready(dout_ready),
        .dout_last(dout_last[0]), .done(done[0])
    );

    pretrig_capture #(.DW(DW), .DEPTH(DEPTH), .PRE(0)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .din(din), .arm(arm), .trig(trig),
        .busy(busy[1]), .triggered(triggered[1]), .dout(dout[1]),
        .dout_valid(dout_valid[1]), .dout_ready(dout_ready),
        .dout_last(dout_last[1]), .done(done[1])
    );

    typedef struct {
        int trig_a;
        int trig_b;
        int en_mode;   // 0 always, 1 low on odd cycles after trig_a, 2 random en and trig
        int rdy_mode;  // 0 always, 1 alternating, 2 random
        int rst_at;    // transfers of the PRE=4 unit before a mid-read reset, -1 none
        bit arm_on_done;
        int first4, last4, first0, last0;
    } vec_t;

    int checks = 0;
    int failures = 0;

    int stored[$];
    int stored_cyc[$];
    int trig_idx[2];
    int got[2];
    int first_out[2];
    int last_out[2];
    int done_due[2];
    bit seen_valid[2];
    bit stall_prev[2];
    int prev_dout[2];
    int prev_last[2];

    function automatic int pre_of(input int p);
        return (p == 0) ? 4 : 0;
    endfunction

    task automatic chk(input string name, input int p, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[u%0d] at %0t: got %0d expected %0d", name, pre_of(p), $time, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int vi);
        int  rst_cyc, arm_chk_cyc, max_due, k, e;
        bit  finished;
        rst = 1'b1; arm = 1'b0; en = 1'b0; trig = 1'b0; dout_ready = 1'b0; din = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        stored.delete();
        stored_cyc.delete();
        for (int p = 0; p < 2; p++) begin
            trig_idx[p] = -1; got[p] = 0; first_out[p] = -1; last_out[p] = -1;
            done_due[p] = 1 << 30; seen_valid[p] = 1'b0; stall_prev[p] = 1'b0;
        end
        rst_cyc = -10; arm_chk_cyc = -10; finished = 1'b0;

        for (int n = 0; n < 600; n++) begin
            arm = (n == 0);
            din = DW'(n);
            case (v.en_mode)
                1:       en = !(n > v.trig_a && n % 2 == 1);
                2:       en = (n == 0) || ($urandom_range(0, 3) != 0);
                default: en = 1'b1;
            endcase
            if (v.en_mode == 2) trig = (n >= 1) && ($urandom_range(0, 7) == 0);
            else                trig = (n == v.trig_a) || (n == v.trig_b);
            case (v.rdy_mode)
                1:       dout_ready = (n % 2 == 0);
                2:       dout_ready = ($urandom_range(0, 1) == 1);
                default: dout_ready = 1'b1;
            endcase
            max_due = (done_due[0] > done_due[1]) ? done_due[0] : done_due[1];
            if (v.arm_on_done && got[0] == DEPTH && got[1] == DEPTH && n == max_due) begin
                arm = 1'b1;
                arm_chk_cyc = n + 1;
            end
            if (v.rst_at >= 0 && rst_cyc < 0 && got[0] == v.rst_at) rst_cyc = n;
            rst = (n == rst_cyc);

            if (n >= 1 && en) begin
                k = stored.size();
                stored.push_back(n % 256);
                stored_cyc.push_back(n);
                for (int p = 0; p < 2; p++)
                    if (trig_idx[p] < 0 && trig && k >= pre_of(p)) trig_idx[p] = k;
            end

            @(negedge clk);
            if (n == rst_cyc + 1) begin
                for (int p = 0; p < 2; p++) begin
                    chk("rst_valid", p, int'(dout_valid[p]), 0);
                    chk("rst_busy", p, int'(busy[p]), 0);
                end
                finished = 1'b1;
                break;
            end
            if (n != rst_cyc) begin
                for (int p = 0; p < 2; p++) begin
                    if (stall_prev[p]) begin
                        chk("stall_valid", p, int'(dout_valid[p]), 1);
                        chk("stall_dout", p, int'(dout[p]), prev_dout[p]);
                        chk("stall_last", p, int'(dout_last[p]), prev_last[p]);
                    end
                    if (dout_valid[p] && !seen_valid[p]) begin
                        seen_valid[p] = 1'b1;
                        e = trig_idx[p] - pre_of(p) + DEPTH - 1;
                        if (trig_idx[p] >= 0 && e < stored_cyc.size())
                            chk("latency", p, n, stored_cyc[e] + 3);
                        else
                            chk("early_valid", p, n, -1);
                        chk("triggered", p, int'(triggered[p]), 1);
                    end
                    if (dout_valid[p] && dout_ready) begin
                        k = trig_idx[p] - pre_of(p) + got[p];
                        chk("dout", p, int'(dout[p]),
                            (trig_idx[p] >= 0 && k < stored.size()) ? stored[k] : -1);
                        chk("last", p, int'(dout_last[p]), int'(got[p] == DEPTH - 1));
                        if (got[p] == 0) first_out[p] = int'(dout[p]);
                        last_out[p] = int'(dout[p]);
                        got[p]++;
                        if (got[p] == DEPTH) done_due[p] = n + 1;
                    end
                    if (n == done_due[p]) begin
                        chk("done", p, int'(done[p]), 1);
                        chk("done_valid", p, int'(dout_valid[p]), 0);
                        chk("done_busy", p, int'(busy[p]), 0);
                    end else begin
                        chk("done_idle", p, int'(done[p]), 0);
                    end
                    if (n == arm_chk_cyc && done_due[p] == n - 1)
                        chk("arm_on_done", p, int'(busy[p]), 0);
                    stall_prev[p] = dout_valid[p] && !dout_ready;
                    prev_dout[p]  = int'(dout[p]);
                    prev_last[p]  = int'(dout_last[p]);
                end
            end
            max_due = (done_due[0] > done_due[1]) ? done_due[0] : done_due[1];
            if (got[0] == DEPTH && got[1] == DEPTH && n >= max_due + (v.arm_on_done ? 1 : 0)) begin
                finished = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        rst = 1'b0;

        if (!finished) begin
            checks++;
            failures++;
            $display("FAIL timeout vec %0d: transfers %0d/%0d required %0d", vi, got[0], got[1], DEPTH);
        end
        if (v.first4 >= 0) chk("first", 0, first_out[0], v.first4);
        if (v.last4  >= 0) chk("final", 0, last_out[0], v.last4);
        if (v.first0 >= 0) chk("first", 1, first_out[1], v.first0);
        if (v.last0  >= 0) chk("final", 1, last_out[1], v.last0);
    endtask

    vec_t vecs[10];

    initial begin
        //          trig_a trig_b en rdy rst_at aod  f4  l4  f0  l0
        vecs[0] = '{20, -1, 0, 0, -1, 1'b0, 16, 31, 20, 35};
        vecs[1] = '{ 1, 30, 0, 0, -1, 1'b0, 26, 41,  1, 16};
        vecs[2] = '{20, -1, 0, 1, -1, 1'b0, 16, 31, 20, 35};
        vecs[3] = '{20, -1, 0, 2, -1, 1'b0, 16, 31, 20, 35};
        vecs[4] = '{ 7, -1, 0, 0, -1, 1'b0,  3, 18,  7, 22};
        vecs[5] = '{20, -1, 1, 0, -1, 1'b0, 16, 42, 20, 50};
        vecs[6] = '{20, -1, 0, 0,  5, 1'b0, 16, -1, -1, -1};
        vecs[7] = '{20, -1, 0, 2, -1, 1'b1, 16, 31, 20, 35};
        vecs[8] = '{-1, -1, 2, 2, -1, 1'b0, -1, -1, -1, -1};
        vecs[9] = '{-1, -1, 2, 0, -1, 1'b1, -1, -1, -1, -1};

        rst = 1'b1; arm = 1'b1; en = 1'b1; trig = 1'b1; dout_ready = 1'b1; din = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            chk("reset_busy", p, int'(busy[p]), 0);
            chk("reset_triggered", p, int'(triggered[p]), 0);
            chk("reset_valid", p, int'(dout_valid[p]), 0);
            chk("reset_last", p, int'(dout_last[p]), 0);
            chk("reset_done", p, int'(done[p]), 0);
            chk("reset_dout", p, int'(dout[p]), 0);
        end

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
